// File: rtl/burst_capture_ctrl.sv
// burst_capture_ctrl
//   Sequencer for the online-arithmetic test harness. A start request seeds
//   the LFSR, enables the DUT for burst_index*max_ram_address cycles, packs
//   burst_index result words per RAM line, then reads every line back and
//   streams the words out over a valid/ready port.
//
// Ports
//   clk, reset     single clock, synchronous active-high reset
//   start          run request, honoured only in IDLE or DONE
//   dut_word       combinational DUT result for the current LFSR state
//   dut_en         clock enable for LFSR and DUT
//   lfsr_reset     one-cycle LFSR seed pulse
//   mem_addr       RAM address (write line n, or read line r)
//   mem_wdata      packed line, word k at bits [(k+1)W-1 : kW]
//   mem_wren       RAM write strobe
//   mem_rdata      RAM read data, valid one cycle after mem_addr
//   rd_data        streamed word
//   rd_valid       rd_data valid
//   rd_ready       consumer accepts rd_data
//   busy, done     run in progress / run complete (level)
module burst_capture_ctrl #(
   parameter  int no_of_digits    = 10,
   parameter  int radix_bits      = 3,
   parameter  int burst_index     = 5,
   parameter  int address_width   = 14,
   parameter  int max_ram_address = 4096,
   localparam int W               = (no_of_digits + 1) * radix_bits,
   localparam int L               = W * burst_index
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [W-1:0]             dut_word,
   output logic                     dut_en,
   output logic                     lfsr_reset,
   output logic [address_width-1:0] mem_addr,
   output logic [L-1:0]             mem_wdata,
   output logic                     mem_wren,
   input  logic [L-1:0]             mem_rdata,
   output logic [W-1:0]             rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int KW = $clog2(burst_index);
   // Line counters carry one extra bit so a full 2^address_width run
   // reaches its terminal count instead of wrapping to 0.
   localparam int CW = address_width + 1;
   localparam logic [KW-1:0] K_LAST = KW'(burst_index - 1);
   localparam logic [CW-1:0] N_LAST = CW'(max_ram_address - 1);
   localparam logic [CW-1:0] N_END  = CW'(max_ram_address);

   typedef enum logic [2:0] {
      IDLE, SEED, CAPTURE, FLUSH, RD_REQ, RD_WAIT, RD_OUT, DONE
   } state_t;

   state_t state, state_nxt;

   logic [KW-1:0]            k, j;
   logic [CW-1:0]            n, r;
   logic [L-1:0]             pack_q, unpack_q, line_full;
   logic [address_width-1:0] waddr_q;
   logic                     line_done, word_last;

   assign line_done = (state == CAPTURE) && (k == K_LAST);
   assign word_last = (j == K_LAST);

   // The last slot goes straight from dut_word into the line so the write
   // can be strobed the cycle after it is sampled.
   always_comb begin
      line_full = pack_q;
      line_full[k*W +: W] = dut_word;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = SEED;
         SEED:       state_nxt = CAPTURE;
         CAPTURE:    if (line_done && (n == N_LAST)) state_nxt = FLUSH;
         FLUSH:      state_nxt = RD_REQ;
         RD_REQ:     state_nxt = RD_WAIT;
         RD_WAIT:    state_nxt = RD_OUT;
         RD_OUT:
            if (rd_ready && word_last)
               state_nxt = ((r + CW'(1)) == N_END) ? DONE : RD_REQ;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dut_en     = (state == CAPTURE);
      lfsr_reset = (state == SEED);
      rd_valid   = (state == RD_OUT);
      busy       = (state != IDLE) && (state != DONE);
      done       = (state == DONE);
      mem_addr   = '0;
      if (mem_wren)              mem_addr = waddr_q;
      else if (state == RD_REQ)  mem_addr = r[address_width-1:0];
      rd_data    = '0;
      if (rd_valid)              rd_data = unpack_q[j*W +: W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k         <= '0;
         j         <= '0;
         n         <= '0;
         r         <= '0;
         pack_q    <= '0;
         unpack_q  <= '0;
         mem_wdata <= '0;
         waddr_q   <= '0;
         mem_wren  <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse after a completed line.
         mem_wren <= 1'b0;
         case (state)
            SEED: begin
               k <= '0;
               j <= '0;
               n <= '0;
               r <= '0;
            end
            CAPTURE: begin
               pack_q[k*W +: W] <= dut_word;
               if (k == K_LAST) begin
                  k         <= '0;
                  mem_wdata <= line_full;
                  waddr_q   <= n[address_width-1:0];
                  mem_wren  <= 1'b1;
                  n         <= n + CW'(1);
               end else begin
                  k <= k + KW'(1);
               end
            end
            RD_WAIT: begin
               unpack_q <= mem_rdata;
               j        <= '0;
            end
            RD_OUT: begin
               if (rd_ready) begin
                  if (word_last) begin
                     j <= '0;
                     r <= r + CW'(1);
                  end else begin
                     j <= j + KW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_capture_ctrl.sv
// Bench for burst_capture_ctrl: main instance (5 words/line, 4 lines) plus
// two boundary instances (1 line of 2 words; 4 lines on a 2-bit address).
module tb_burst_capture_ctrl;
   localparam int W   = 33;
   localparam int BI  = 5;
   localparam int MAX = 4;
   localparam int AW  = 14;
   localparam int LA  = W * BI;
   localparam int LB  = W * 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   tests = 0;
   int   fails = 0;

   // main instance
   logic          start, dut_en, lfsr_reset, mem_wren, rd_valid, rd_ready, busy, done;
   logic [W-1:0]  dut_word, rd_data, stim_a;
   logic [AW-1:0] mem_addr;
   logic [LA-1:0] mem_wdata, mem_rdata;
   logic [LA-1:0] ram_a [0:3];
   logic [W-1:0]  q_a[$];

   burst_capture_ctrl #(.burst_index(BI), .address_width(AW), .max_ram_address(MAX)) u_dut (
      .clk(clk), .reset(reset), .start(start), .dut_word(dut_word), .dut_en(dut_en),
      .lfsr_reset(lfsr_reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done));

   // instance b: one line of two words
   logic          start_b, b_dut_en, b_lfsr_reset, b_mem_wren, b_rd_valid, b_rd_ready, b_busy, b_done;
   logic [W-1:0]  b_dut_word, b_rd_data, stim_b;
   logic [AW-1:0] b_mem_addr;
   logic [LB-1:0] b_mem_wdata, b_mem_rdata, ram_b;
   logic [W-1:0]  q_b[$];

   burst_capture_ctrl #(.burst_index(2), .address_width(AW), .max_ram_address(1)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .dut_word(b_dut_word), .dut_en(b_dut_en),
      .lfsr_reset(b_lfsr_reset), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren),
      .mem_rdata(b_mem_rdata), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
      .busy(b_busy), .done(b_done));

   // instance c: full 2-bit address space
   logic          start_c, c_dut_en, c_lfsr_reset, c_mem_wren, c_rd_valid, c_rd_ready, c_busy, c_done;
   logic [W-1:0]  c_dut_word, c_rd_data, stim_c;
   logic [1:0]    c_mem_addr;
   logic [LB-1:0] c_mem_wdata, c_mem_rdata;
   logic [LB-1:0] ram_c [0:3];
   logic [W-1:0]  q_c[$];

   burst_capture_ctrl #(.burst_index(2), .address_width(2), .max_ram_address(4)) u_dut_c (
      .clk(clk), .reset(reset), .start(start_c), .dut_word(c_dut_word), .dut_en(c_dut_en),
      .lfsr_reset(c_lfsr_reset), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_wren(c_mem_wren),
      .mem_rdata(c_mem_rdata), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_ready(c_rd_ready),
      .busy(c_busy), .done(c_done));

   // Stimulus: running count, reseeded to 0 by lfsr_reset, advanced by dut_en.
   assign dut_word   = stim_a;
   assign b_dut_word = stim_b;
   assign c_dut_word = stim_c;

   always_ff @(posedge clk) begin
      if (reset || lfsr_reset)       stim_a <= '0;
      else if (dut_en)               stim_a <= stim_a + W'(1);
      if (reset || b_lfsr_reset)     stim_b <= '0;
      else if (b_dut_en)             stim_b <= stim_b + W'(1);
      if (reset || c_lfsr_reset)     stim_c <= '0;
      else if (c_dut_en)             stim_c <= stim_c + W'(1);
   end

   // RAM models with one-cycle read latency.
   always_ff @(posedge clk) begin
      if (mem_wren)   ram_a[mem_addr[1:0]] <= mem_wdata;
      mem_rdata <= ram_a[mem_addr[1:0]];
      if (b_mem_wren) ram_b <= b_mem_wdata;
      b_mem_rdata <= ram_b;
      if (c_mem_wren) ram_c[c_mem_addr] <= c_mem_wdata;
      c_mem_rdata <= ram_c[c_mem_addr];
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({dut_en, lfsr_reset, mem_wren, rd_valid, busy, done} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b expected 000000", {dut_en, lfsr_reset, mem_wren, rd_valid, busy, done});
      end
      tests++;
      if (mem_addr !== '0 || rd_data !== '0) begin
         fails++;
         $display("FAIL reset_data: mem_addr=%0h rd_data=%0h expected 0", mem_addr, rd_data);
      end
      tests++;
      if ({b_busy, b_done, b_mem_wren, c_busy, c_done, c_mem_wren} !== 6'b0) begin
         fails++;
         $display("FAIL reset_boundary: got %b expected 000000", {b_busy, b_done, b_mem_wren, c_busy, c_done, c_mem_wren});
      end
   endtask

   // Full capture + readback on the main instance, starting from IDLE or DONE.
   task automatic run_main(input string tag, input bit bp, input bit hold_start);
      int cyc = 0, t_seed = -1, t_en = -1, en_cnt = 0, seed_cnt = 0;
      int wr_cnt = 0, acc = 0, last_acc = -1, t_done = -1;
      bit en_prev = 1'b0, en_gap = 1'b0, stall = 1'b0, tog = 1'b0;
      logic [W-1:0]  stall_data = '0, exp_w;
      logic [LA-1:0] exp_line;
      q_a.delete();
      start = 1'b1;
      while (t_done < 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (!hold_start) start = 1'b0;
         if (cyc == 1) begin
            tests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               fails++;
               $display("FAIL %s start_ack: done=%b busy=%b expected done=0 busy=1", tag, done, busy);
            end
         end
         if (lfsr_reset) begin seed_cnt++; t_seed = cyc; end
         if (dut_en) begin
            if (t_en < 0) t_en = cyc;
            else if (!en_prev) en_gap = 1'b1;
            en_cnt++;
            q_a.push_back(dut_word);
         end
         en_prev = dut_en;
         if (mem_wren) begin
            for (int s = 0; s < BI; s++) exp_line[s*W +: W] = W'(wr_cnt * BI + s);
            tests++;
            if (mem_addr !== AW'(wr_cnt) || mem_wdata !== exp_line || cyc != t_en + (wr_cnt + 1) * BI) begin
               fails++;
               $display("FAIL %s write%0d: addr=%0h cyc=%0d data=%0h expected addr=%0h cyc=%0d data=%0h",
                        tag, wr_cnt, mem_addr, cyc, mem_wdata, wr_cnt, t_en + (wr_cnt + 1) * BI, exp_line);
            end
            wr_cnt++;
         end
         if (stall) begin
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== stall_data) begin
               fails++;
               $display("FAIL %s hold: valid=%b data=%0h expected valid=1 data=%0h", tag, rd_valid, rd_data, stall_data);
            end
         end
         rd_ready = bp ? tog : 1'b1;
         if (rd_valid) tog = !tog;
         if (rd_valid && rd_ready) begin
            tests++;
            if (q_a.size() == 0) begin
               fails++;
               $display("FAIL %s extra_word: got %0h expected none", tag, rd_data);
            end else begin
               exp_w = q_a.pop_front();
               if (rd_data !== exp_w) begin
                  fails++;
                  $display("FAIL %s word%0d: got %0h expected %0h", tag, acc, rd_data, exp_w);
               end
            end
            if (!bp) begin
               tests++;
               if (cyc != t_en + BI * MAX + 3 + (acc / BI) * (BI + 2) + acc % BI) begin
                  fails++;
                  $display("FAIL %s accept_time%0d: got %0d expected %0d", tag, acc, cyc,
                           t_en + BI * MAX + 3 + (acc / BI) * (BI + 2) + acc % BI);
               end
            end
            acc++;
            last_acc = cyc;
         end
         stall      = rd_valid && !rd_ready;
         stall_data = rd_data;
         if (done) t_done = cyc;
      end
      start = 1'b0;
      tests++;
      if (t_done < 0) begin fails++; $display("FAIL %s timeout: done not seen after %0d cycles", tag, cyc); end
      tests++;
      if (seed_cnt != 1 || t_seed != 1) begin
         fails++;
         $display("FAIL %s seed: pulses=%0d at=%0d expected 1 at 1", tag, seed_cnt, t_seed);
      end
      tests++;
      if (t_en != 2 || en_cnt != BI * MAX || en_gap) begin
         fails++;
         $display("FAIL %s dut_en: first=%0d count=%0d gap=%b expected 2 %0d 0", tag, t_en, en_cnt, en_gap, BI * MAX);
      end
      tests++;
      if (wr_cnt != MAX) begin fails++; $display("FAIL %s writes: got %0d expected %0d", tag, wr_cnt, MAX); end
      tests++;
      if (acc != BI * MAX || q_a.size() != 0) begin
         fails++;
         $display("FAIL %s words: got %0d left=%0d expected %0d left=0", tag, acc, q_a.size(), BI * MAX);
      end
      tests++;
      if (t_done != last_acc + 1 || busy !== 1'b0 || done !== 1'b1) begin
         fails++;
         $display("FAIL %s done_edge: done_at=%0d busy=%b expected %0d busy=0", tag, t_done, busy, last_acc + 1);
      end
      if (!bp) begin
         tests++;
         if (t_done != 3 + BI * MAX + MAX * (BI + 2)) begin
            fails++;
            $display("FAIL %s run_len: got %0d expected %0d", tag, t_done, 3 + BI * MAX + MAX * (BI + 2));
         end
      end
   endtask

   task automatic test_capture_readback(); run_main("capture_readback", 1'b0, 1'b0); endtask
   task automatic test_backpressure();     run_main("backpressure", 1'b1, 1'b0);     endtask
   task automatic test_start_held();       run_main("start_held", 1'b0, 1'b1);       endtask
   task automatic test_restart();          run_main("restart", 1'b0, 1'b0);          endtask

   task automatic test_reset_mid_run();
      int cyc = 0, first_wr = -1;
      bit bad_wr = 1'b0;
      logic [LA-1:0] exp_line;
      start = 1'b1;
      while (cyc < 11) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (mem_wren && mem_addr !== AW'(0)) bad_wr = 1'b1;
      end
      tests++;
      if (dut_en !== 1'b1) begin fails++; $display("FAIL midrst_pre: dut_en=%b expected 1", dut_en); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if ({mem_wren, dut_en, busy, done, lfsr_reset} !== 5'b0) begin
         fails++;
         $display("FAIL midrst_idle: wren,en,busy,done,seed=%b expected 00000", {mem_wren, dut_en, busy, done, lfsr_reset});
      end
      repeat (4) begin
         @(negedge clk);
         if (mem_wren) bad_wr = 1'b1;
      end
      tests++;
      if (bad_wr || busy !== 1'b0) begin
         fails++;
         $display("FAIL midrst_nowrite: stray_write=%b busy=%b expected 0 0", bad_wr, busy);
      end
      start = 1'b1;
      cyc = 0;
      while (first_wr < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (mem_wren) begin
            first_wr = cyc;
            for (int s = 0; s < BI; s++) exp_line[s*W +: W] = W'(s);
            tests++;
            if (mem_addr !== AW'(0) || mem_wdata !== exp_line) begin
               fails++;
               $display("FAIL midrst_rerun: addr=%0h data=%0h expected 0 %0h", mem_addr, mem_wdata, exp_line);
            end
         end
      end
      tests++;
      if (first_wr != 7) begin fails++; $display("FAIL midrst_first_wr: at %0d expected 7", first_wr); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_boundary();
      int cyc = 0, wb = 0, wc = 0, ab = 0, ac = 0, db = -1, dc = -1;
      logic [W-1:0] exp_w;
      q_b.delete();
      q_c.delete();
      start_b = 1'b1;
      start_c = 1'b1;
      while ((db < 0 || dc < 0) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start_b = 1'b0;
         start_c = 1'b0;
         if (b_dut_en) q_b.push_back(b_dut_word);
         if (c_dut_en) q_c.push_back(c_dut_word);
         if (b_mem_wren) begin
            tests++;
            if (b_mem_addr !== AW'(0) || b_mem_wdata !== {W'(1), W'(0)} || cyc != 4) begin
               fails++;
               $display("FAIL bnd_b_write: addr=%0h data=%0h cyc=%0d expected 0 %0h 4", b_mem_addr, b_mem_wdata, cyc, {W'(1), W'(0)});
            end
            wb++;
         end
         if (c_mem_wren) begin
            tests++;
            if (c_mem_addr !== 2'(wc) || c_mem_wdata !== {W'(2 * wc + 1), W'(2 * wc)} || cyc != 2 + (wc + 1) * 2) begin
               fails++;
               $display("FAIL bnd_c_write%0d: addr=%0h data=%0h cyc=%0d expected %0h %0h %0d", wc, c_mem_addr, c_mem_wdata,
                        cyc, wc, {W'(2 * wc + 1), W'(2 * wc)}, 2 + (wc + 1) * 2);
            end
            wc++;
         end
         if (b_rd_valid) begin
            tests++;
            exp_w = (q_b.size() != 0) ? q_b.pop_front() : 'x;
            if (b_rd_data !== exp_w) begin fails++; $display("FAIL bnd_b_word%0d: got %0h expected %0h", ab, b_rd_data, exp_w); end
            ab++;
         end
         if (c_rd_valid) begin
            tests++;
            exp_w = (q_c.size() != 0) ? q_c.pop_front() : 'x;
            if (c_rd_data !== exp_w) begin fails++; $display("FAIL bnd_c_word%0d: got %0h expected %0h", ac, c_rd_data, exp_w); end
            ac++;
         end
         if (b_done && db < 0) db = cyc;
         if (c_done && dc < 0) dc = cyc;
      end
      tests++;
      if (wb != 1 || ab != 2 || db != 9) begin
         fails++;
         $display("FAIL bnd_b_run: writes=%0d words=%0d done_at=%0d expected 1 2 9", wb, ab, db);
      end
      tests++;
      if (wc != 4 || ac != 8 || dc != 27) begin
         fails++;
         $display("FAIL bnd_c_run: writes=%0d words=%0d done_at=%0d expected 4 8 27", wc, ac, dc);
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_b    = 1'b0;
      start_c    = 1'b0;
      rd_ready   = 1'b1;
      b_rd_ready = 1'b1;
      c_rd_ready = 1'b1;
      test_reset();
      test_capture_readback();
      test_backpressure();
      test_start_held();
      test_restart();
      test_reset_mid_run();
      test_boundary();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
